// File: rtl/fetch_sequencer_pkg.sv
// Shared types and defaults for the PC/nPC fetch sequencer.
package fetch_sequencer_pkg;

  typedef logic [31:0] addr_t;

  localparam addr_t DEF_RESET_PC = 32'd0;
  localparam addr_t DEF_INC      = 32'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // How the PC/nPC pair updates on the next edge.
  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_SEQ  = 2'd1,
    SEL_TA   = 2'd2,
    SEL_JMPL = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Redirect/hazard inputs and fetch outputs of the fetch sequencer.
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic        stall;
  logic        ta_valid;
  addr_t       ta;
  logic        jmpl_valid;
  addr_t       jmpl_addr;
  logic        annul_req;
  addr_t       PC;
  addr_t       nPC;
  logic        ifid_le;
  logic        ifid_clr;
  logic [31:0] fetch_count;
  logic        conflict_err;

  modport master (
    output stall, ta_valid, ta, jmpl_valid, jmpl_addr, annul_req,
    input  PC, nPC, ifid_le, ifid_clr, fetch_count, conflict_err
  );

  modport slave (
    input  stall, ta_valid, ta, jmpl_valid, jmpl_addr, annul_req,
    output PC, nPC, ifid_le, ifid_clr, fetch_count, conflict_err
  );

endinterface

// File: rtl/fetch_sequencer_pc_npc_reg.sv
// PC/nPC register pair; the select input chooses hold, sequential, branch or jmpl update.
module fetch_sequencer_pc_npc_reg
  import fetch_sequencer_pkg::*;
#(
  parameter addr_t RESET_PC = DEF_RESET_PC,
  parameter addr_t INC      = DEF_INC
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  pc_sel_e i_sel,
  input  addr_t   i_ta,
  input  addr_t   i_jmpl_addr,
  output addr_t   o_pc,
  output addr_t   o_npc
);

  addr_t r_pc;
  addr_t r_npc;
  addr_t w_pc_nxt;
  addr_t w_npc_nxt;

  // Next PC/nPC selection; a taken branch still fetches the delay slot at nPC.
  always_comb begin
    w_pc_nxt  = r_pc;
    w_npc_nxt = r_npc;
    case (i_sel)
      SEL_HOLD: begin
        w_pc_nxt  = r_pc;
        w_npc_nxt = r_npc;
      end
      SEL_SEQ: begin
        w_pc_nxt  = r_npc;
        w_npc_nxt = r_npc + INC;
      end
      SEL_TA: begin
        w_pc_nxt  = r_npc;
        w_npc_nxt = i_ta;
      end
      SEL_JMPL: begin
        w_pc_nxt  = i_jmpl_addr;
        w_npc_nxt = i_jmpl_addr + INC;
      end
      default: begin
        w_pc_nxt  = r_pc;
        w_npc_nxt = r_npc;
      end
    endcase
  end

  // PC/nPC state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc  <= RESET_PC;
      r_npc <= RESET_PC + INC;
    end else begin
      r_pc  <= w_pc_nxt;
      r_npc <= w_npc_nxt;
    end
  end

  assign o_pc  = r_pc;
  assign o_npc = r_npc;

endmodule

// File: rtl/fetch_sequencer.sv
// SPARC-style PC/nPC fetch sequencer with delayed branches, jmpl redirects, stalls and annul.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter addr_t RESET_PC = DEF_RESET_PC,
  parameter addr_t INC      = DEF_INC
) (
  input logic              i_clk,
  input logic              i_rst,
  fetch_sequencer_if.slave io_bus
);

  state_e      r_state;
  state_e      w_state_nxt;
  pc_sel_e     w_sel;
  logic        w_ifid_le;
  logic        w_ifid_clr;
  logic        w_count_en;
  logic        w_conflict;
  logic [31:0] r_fetch_count;
  logic        r_conflict_err;
  addr_t       w_pc;
  addr_t       w_npc;

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, PC/nPC select and IF/ID controls; jmpl outranks stall, stall outranks annul.
  always_comb begin
    w_state_nxt = r_state;
    w_sel       = SEL_HOLD;
    w_ifid_le   = 1'b1;
    w_ifid_clr  = 1'b1;
    w_count_en  = 1'b0;
    w_conflict  = 1'b0;
    case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
      end
      RUN, HOLD: begin
        if (io_bus.jmpl_valid) begin
          w_sel       = SEL_JMPL;
          w_conflict  = io_bus.stall;
          w_state_nxt = RUN;
        end else if (io_bus.stall) begin
          w_ifid_le   = 1'b0;
          w_ifid_clr  = 1'b0;
          w_state_nxt = HOLD;
        end else begin
          w_sel       = io_bus.ta_valid ? SEL_TA : SEL_SEQ;
          w_ifid_clr  = io_bus.annul_req;
          w_count_en  = ~io_bus.annul_req;
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  // Accepted-fetch counter and sticky stall/jmpl conflict flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fetch_count  <= 32'd0;
      r_conflict_err <= 1'b0;
    end else begin
      if (w_count_en) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_conflict) begin
        r_conflict_err <= 1'b1;
      end
    end
  end

  fetch_sequencer_pc_npc_reg #(
    .RESET_PC (RESET_PC),
    .INC      (INC)
  ) u_pc_npc_reg (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_sel       (w_sel),
    .i_ta        (io_bus.ta),
    .i_jmpl_addr (io_bus.jmpl_addr),
    .o_pc        (w_pc),
    .o_npc       (w_npc)
  );

  assign io_bus.PC           = w_pc;
  assign io_bus.nPC          = w_npc;
  assign io_bus.ifid_le      = w_ifid_le;
  assign io_bus.ifid_clr     = w_ifid_clr;
  assign io_bus.fetch_count  = r_fetch_count;
  assign io_bus.conflict_err = r_conflict_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a behavioural model queues expected results per edge.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  typedef struct packed {
    logic        le;
    logic        clr;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] cnt;
    logic        conf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  state_e      m_state;
  logic [31:0] m_pc;
  logic [31:0] m_npc;
  logic [31:0] m_cnt;
  logic        m_conf;
  logic        obs_le;
  logic        obs_clr;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = BOOT;
    m_pc    = 32'd0;
    m_npc   = 32'd4;
    m_cnt   = 32'd0;
    m_conf  = 1'b0;
  endtask

  // Drive one edge's inputs, queue the model's prediction, then compare after the edge.
  task automatic step(input string tag, input logic st, input logic tv, input logic [31:0] t,
                      input logic jv, input logic [31:0] ja, input logic an);
    exp_t e;
    bus.stall      = st;
    bus.ta_valid   = tv;
    bus.ta         = t;
    bus.jmpl_valid = jv;
    bus.jmpl_addr  = ja;
    bus.annul_req  = an;
    e.le  = 1'b1;
    e.clr = 1'b1;
    if (m_state == BOOT) begin
      m_state = RUN;
    end else if (jv) begin
      m_pc  = ja;
      m_npc = ja + 32'd4;
      if (st) m_conf = 1'b1;
      m_state = RUN;
    end else if (st) begin
      e.le    = 1'b0;
      e.clr   = 1'b0;
      m_state = HOLD;
    end else begin
      e.clr = an;
      if (!an) m_cnt = m_cnt + 32'd1;
      m_pc    = m_npc;
      m_npc   = tv ? t : (m_npc + 32'd4);
      m_state = RUN;
    end
    e.pc   = m_pc;
    e.npc  = m_npc;
    e.cnt  = m_cnt;
    e.conf = m_conf;
    sb_q.push_back(e);
    #1;
    obs_le  = bus.ifid_le;
    obs_clr = bus.ifid_clr;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s.queue: got empty expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, ".le"},   {31'd0, obs_le},           {31'd0, e.le});
      check_eq({tag, ".clr"},  {31'd0, obs_clr},          {31'd0, e.clr});
      check_eq({tag, ".pc"},   bus.PC,                    e.pc);
      check_eq({tag, ".npc"},  bus.nPC,                   e.npc);
      check_eq({tag, ".cnt"},  bus.fetch_count,           e.cnt);
      check_eq({tag, ".conf"}, {31'd0, bus.conflict_err}, {31'd0, e.conf});
    end
  endtask

  task automatic seq(input string tag);
    step(tag, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.stall      = 1'b0;
    bus.ta_valid   = 1'b0;
    bus.ta         = 32'd0;
    bus.jmpl_valid = 1'b0;
    bus.jmpl_addr  = 32'd0;
    bus.annul_req  = 1'b0;
    model_reset();
    #1;
    check_eq("rst.pc",   bus.PC,                    32'd0);
    check_eq("rst.npc",  bus.nPC,                   32'd4);
    check_eq("rst.le",   {31'd0, bus.ifid_le},      32'd1);
    check_eq("rst.clr",  {31'd0, bus.ifid_clr},     32'd1);
    check_eq("rst.cnt",  bus.fetch_count,           32'd0);
    check_eq("rst.conf", {31'd0, bus.conflict_err}, 32'd0);
    #2;
    rst = 1'b0;

    // Boot then free run, branch at PC=8 to 40.
    seq("boot");
    check_eq("tp.boot_pc", bus.PC, 32'd0);
    seq("run1");
    seq("run2");
    check_eq("tp.pc8", bus.PC, 32'd8);
    step("br", 1'b0, 1'b1, 32'd40, 1'b0, 32'd0, 1'b0);
    check_eq("tp.slot_pc", bus.PC, 32'd12);
    check_eq("tp.cnt3", bus.fetch_count, 32'd3);
    seq("br_t");
    check_eq("tp.br_pc40", bus.PC, 32'd40);
    seq("br_t4");
    check_eq("tp.br_pc44", bus.PC, 32'd44);

    // Annulled branch from PC=8 (ba,a).
    step("j8", 1'b0, 1'b0, 32'd0, 1'b1, 32'd8, 1'b0);
    step("bra", 1'b0, 1'b1, 32'd40, 1'b0, 32'd0, 1'b1);
    check_eq("tp.bra_pc12", bus.PC, 32'd12);
    check_eq("tp.bra_cnt", bus.fetch_count, 32'd5);
    seq("bra_t");
    check_eq("tp.bra_pc40", bus.PC, 32'd40);

    // Three-cycle stall at PC=16, then jmpl at PC=20.
    step("j16", 1'b0, 1'b0, 32'd0, 1'b1, 32'd16, 1'b0);
    for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    check_eq("tp.stall_pc", bus.PC, 32'd16);
    seq("unstall");
    check_eq("tp.pc20", bus.PC, 32'd20);
    step("jmpl", 1'b0, 1'b0, 32'd0, 1'b1, 32'd100, 1'b0);
    check_eq("tp.jmpl_pc", bus.PC, 32'd100);
    check_eq("tp.jmpl_npc", bus.nPC, 32'd104);

    // Branch held stable across a stall, then stall+jmpl conflict.
    for (int i = 0; i < 2; i++) step("hold_br", 1'b1, 1'b1, 32'd80, 1'b0, 32'd0, 1'b0);
    step("rel_br", 1'b0, 1'b1, 32'd80, 1'b0, 32'd0, 1'b0);
    step("conf", 1'b1, 1'b0, 32'd0, 1'b1, 32'd200, 1'b0);
    seq("conf_s1");
    seq("conf_s2");
    check_eq("tp.conf_sticky", {31'd0, bus.conflict_err}, 32'd1);

    // Address wrap.
    step("jwrap", 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFF8, 1'b0);
    seq("wrap1");
    check_eq("tp.wrap_npc", bus.nPC, 32'd0);
    seq("wrap2");

    // Mixed random traffic against the model.
    for (int i = 0; i < 40; i++) begin
      step("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           ($urandom() & 32'hFFFF_FFFC), ($urandom_range(0, 7) == 0),
           ($urandom() & 32'hFFFF_FFFC), ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset in the middle of a HOLD.
    step("mh1", 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    step("mh2", 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_eq("mrst.pc",   bus.PC,                    32'd0);
    check_eq("mrst.npc",  bus.nPC,                   32'd4);
    check_eq("mrst.le",   {31'd0, bus.ifid_le},      32'd1);
    check_eq("mrst.clr",  {31'd0, bus.ifid_clr},     32'd1);
    check_eq("mrst.cnt",  bus.fetch_count,           32'd0);
    check_eq("mrst.conf", {31'd0, bus.conflict_err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seq("boot2");
    seq("run_after");
    check_eq("tp.after_pc", bus.PC, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

SPARC-style PC/nPC fetch sequencer at the head of the pipeline. It feeds the instruction memory address and the IF/ID pipeline register, with delayed-branch semantics. Inputs are ID-stage branch/call redirects, EX-stage jmpl redirects, hazard stalls and delay-slot annul requests. Outputs are PC, nPC, IF/ID load/clear controls and a fetch counter.

## Interface
- RESET_PC, 32'd0, PC value on reset.
- INC, 32'd4, sequential nPC increment.
- Clk  in  1  clock, all state updates on rising edge.
- R  in  1  reset, asynchronous, active-high.
- stall  in  1  load-use hold from the hazard unit; freezes PC, nPC and IF/ID.
- ta_valid  in  1  taken branch or call resolved in ID.
- ta  in  32  target address from ID.
- jmpl_valid  in  1  jmpl resolved in EX.
- jmpl_addr  in  32  EX ALU result (jmpl target).
- annul_req  in  1  annul the delay-slot instruction currently in IF.
- PC  out  32  fetch address to instruction memory.
- nPC  out  32  next PC.
- ifid_le  out  1  IF/ID load enable.
- ifid_clr  out  1  IF/ID synchronous clear; loads a nop.
- fetch_count  out  32  instructions fetched and accepted since reset.
- conflict_err  out  1  sticky; stall and jmpl_valid were seen together.

## Operation
- FSM states: BOOT, RUN, HOLD.
- Reset (R=1 at any time, including mid-redirect):
  - state=BOOT, PC=RESET_PC, nPC=RESET_PC+INC.
  - fetch_count=0, conflict_err=0.
- BOOT:
  - Lasts one cycle after R falls.
  - ifid_clr=1, ifid_le=1, PC and nPC unchanged. The first IF/ID capture is a nop.
  - Next state is RUN.
- RUN, per-edge priority (highest first):
  - jmpl_valid: PC<=jmpl_addr, nPC<=jmpl_addr+INC, ifid_clr=1 (squashes the instruction after the delay slot). If stall is also high, set conflict_err.
  - stall: PC and nPC hold, ifid_le=0, ifid_clr=0, state<=HOLD.
  - ta_valid: PC<=nPC (the delay slot is fetched), nPC<=ta.
  - Default: PC<=nPC, nPC<=nPC+INC.
- annul_req:
  - Applies when jmpl_valid=0 and stall=0; ignored otherwise.
  - Asserts ifid_clr=1 and does not change PC/nPC sequencing.
  - May coincide with ta_valid; both take effect (the ba,a case).
- HOLD:
  - Same actions as RUN.
  - Returns to RUN on the first edge with stall=0.
  - Upstream holds ta_valid/ta stable while stall=1.
- fetch_count:
  - Increments by 1 on every edge where PC advances and ifid_clr=0.
  - Wraps modulo 2^32.
- Arithmetic: all additions 32-bit unsigned and wrap, e.g. nPC=FFFFFFFC gives FFFFFFFC+4=00000000.

## Timing
- PC, nPC, fetch_count and conflict_err are registered.
- ifid_le and ifid_clr are combinational from state and inputs, valid before the edge they act on.
- Redirect latency:
  - ta_valid sampled at edge k: PC=ta after edge k+1 (one delay slot).
  - jmpl_valid sampled at edge k: PC=jmpl_addr after edge k.
- Reset values: PC=RESET_PC, nPC=RESET_PC+4, ifid_le=1, ifid_clr=1, fetch_count=0, conflict_err=0.
- A stall lasting N cycles holds PC for exactly N edges.

## Structure
- Shared package holds:
  - state encoding: BOOT=2'd0, RUN=2'd1, HOLD=2'd2.
  - INC and RESET_PC defaults.
  - 32-bit address typedef.
- One natural sub-module: pc_npc_reg. It is the PC/nPC register pair with async reset and a hold/load-select input. The FSM and counter stay in the top.

## Test plan
- Reset then free run: R high 0–3 ns. Require:
  - BOOT cycle with ifid_clr=1.
  - Then PC = 0, 4, 8, 12 on consecutive edges.
  - fetch_count=3 after the third advance.
- Branch: at PC=8, nPC=12, pulse ta_valid with ta=40. Require PC=12 (delay slot), then 40, then 44.
- Annulled branch: repeat the branch test with annul_req=1. Require:
  - ifid_clr=1 on that edge.
  - PC sequence still 12, then 40.
  - fetch_count not incremented for the annulled slot.
- jmpl: at PC=20, pulse jmpl_valid with jmpl_addr=100. Require PC=100, nPC=104 and ifid_clr=1 on that edge.
- Stall: hold stall 3 cycles at PC=16. Require:
  - PC=16 and ifid_le=0 for 3 edges.
  - Then PC=20.
  - stall plus jmpl_valid together sets conflict_err=1; it stays 1 until R.
- Wrap and mid-run reset: with nPC=FFFFFFFC, the next nPC is 0. Asserting R mid-HOLD immediately returns to PC=0, nPC=4, state BOOT.
